// File: rtl/ei_axi4_pkg.sv
// Shared types and constants for the AXI4 write-beat generator.
// Burst encoding, FSM state type and the 4KB page size used by the optional page check.
package ei_axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic [31:0] PAGE_4KB_BYTES = 32'h0000_1000;

endpackage

// File: rtl/ei_axi4_wstrb_calc.sv
// Combinational strobe and next-address calculator for one AXI4 write beat.
// Handles FIXED/INCR/WRAP addressing; all arithmetic is modulo 2**32.
module ei_axi4_wstrb_calc
    import ei_axi4_pkg::*;
#(
    parameter int BUS_BYTE_LANES = 4
) (
    input  logic [31:0]               addr,
    input  burst_e                    burst,
    input  logic [2:0]                size,
    input  logic [7:0]                len,
    input  logic [7:0]                beat_no,
    output logic [BUS_BYTE_LANES-1:0] wstrb,
    output logic [31:0]               next_addr
);

    logic [31:0] bytes;
    logic [31:0] off;
    logic [31:0] aligned;
    logic [31:0] lane_base;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] total;
    logic [31:0] lower;
    logic [31:0] incr_addr;
    logic        partial;

    always_comb begin
        bytes     = 32'd1 << size;
        off       = addr & (bytes - 32'd1);
        aligned   = addr & ~(bytes - 32'd1);
        lane_base = aligned & 32'(BUS_BYTE_LANES - 1);
        // only beat 0 and FIXED beats may start mid-container; later beats are aligned
        partial   = (beat_no == 8'd0) || (burst == BURST_FIXED);
        lo        = lane_base + (partial ? off : 32'd0);
        hi        = lane_base + bytes;
        wstrb     = '0;
        for (int i = 0; i < BUS_BYTE_LANES; i++) begin
            wstrb[i] = (32'(i) >= lo) && (32'(i) < hi);
        end

        total     = bytes * (32'(len) + 32'd1);
        lower     = aligned & ~(total - 32'd1);
        incr_addr = aligned + bytes;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (incr_addr == lower + total) ? lower : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/ei_axi4_wbeat_gen.sv
// AXI4 W-channel beat generator: takes a write-burst command and streams upstream beats with strobes/wlast.
// Optional macro EI_AXI4_WBEAT_4KB_CHECK_EN rejects INCR bursts that cross a 4KB page.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_BURST | passing beats from src to W channel until the wlast handshake
module ei_axi4_wbeat_gen
    import ei_axi4_pkg::*;
#(
    parameter int BUS_BYTE_LANES = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [31:0]                 cmd_addr,
    input  logic [1:0]                  cmd_burst,
    input  logic [2:0]                  cmd_size,
    input  logic [7:0]                  cmd_len,
    input  logic                        src_valid,
    output logic                        src_ready,
    input  logic [8*BUS_BYTE_LANES-1:0] src_data,
    output logic                        wvalid,
    input  logic                        wready,
    output logic [8*BUS_BYTE_LANES-1:0] wdata,
    output logic [BUS_BYTE_LANES-1:0]   wstrb,
    output logic                        wlast,
    output logic                        busy,
    output logic                        cmd_err
);

    state_e                      state;
    state_e                      state_nxt;
    logic [31:0]                 addr_q;
    logic [7:0]                  beat_q;
    logic [7:0]                  len_q;
    logic [2:0]                  size_q;
    burst_e                      burst_q;
    logic                        cmd_err_q;

    logic                        cmd_fire;
    logic                        cmd_illegal;
    logic                        page_cross;
    logic                        beat_fire;
    logic                        last_beat;
    logic [31:0]                 cmd_bytes;
    burst_e                      cmd_burst_e;
    logic [BUS_BYTE_LANES-1:0]   strb_calc;
    logic [31:0]                 next_addr_calc;

    assign cmd_burst_e = burst_e'(cmd_burst);
    assign cmd_bytes   = 32'd1 << cmd_size;
    assign cmd_fire    = cmd_valid && (state == ST_IDLE);
    assign beat_fire   = (state == ST_BURST) && src_valid && wready;
    assign last_beat   = (beat_q == len_q);

`ifdef EI_AXI4_WBEAT_4KB_CHECK_EN
    logic [31:0] cmd_last_byte;
    assign cmd_last_byte = (cmd_addr & ~(cmd_bytes - 32'd1))
                         + cmd_bytes * (32'(cmd_len) + 32'd1) - 32'd1;
    assign page_cross    = (cmd_burst_e == BURST_INCR) &&
                           ((cmd_addr & ~(PAGE_4KB_BYTES - 32'd1)) !=
                            (cmd_last_byte & ~(PAGE_4KB_BYTES - 32'd1)));
`else
    assign page_cross    = 1'b0;
`endif

    always_comb begin
        cmd_illegal = 1'b0;
        if (cmd_bytes > 32'(BUS_BYTE_LANES)) cmd_illegal = 1'b1;
        if (cmd_burst_e == BURST_RSVD)       cmd_illegal = 1'b1;
        if (cmd_burst_e == BURST_WRAP) begin
            if (!((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                  (cmd_len == 8'd7) || (cmd_len == 8'd15)))
                cmd_illegal = 1'b1;
            if ((cmd_addr & (cmd_bytes - 32'd1)) != 32'd0)
                cmd_illegal = 1'b1;
        end
        if (page_cross) cmd_illegal = 1'b1;
    end

    ei_axi4_wstrb_calc #(
        .BUS_BYTE_LANES (BUS_BYTE_LANES)
    ) u_wstrb_calc (
        .addr      (addr_q),
        .burst     (burst_q),
        .size      (size_q),
        .len       (len_q),
        .beat_no   (beat_q),
        .wstrb     (strb_calc),
        .next_addr (next_addr_calc)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_fire && !cmd_illegal) state_nxt = ST_BURST;
            ST_BURST: if (beat_fire && last_beat)   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        src_ready = 1'b0;
        wvalid    = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        wlast     = 1'b0;
        case (state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_BURST: begin
                busy      = 1'b1;
                src_ready = wready;
                wvalid    = src_valid;
                wdata     = src_data;
                wstrb     = strb_calc;
                wlast     = last_beat;
            end
            default: ;
        endcase
    end

    assign cmd_err = cmd_err_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q    <= 32'd0;
            beat_q    <= 8'd0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= BURST_FIXED;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= cmd_fire && cmd_illegal;
            if (cmd_fire && !cmd_illegal) begin
                addr_q  <= cmd_addr;
                beat_q  <= 8'd0;
                len_q   <= cmd_len;
                size_q  <= cmd_size;
                burst_q <= cmd_burst_e;
            end else if (beat_fire) begin
                addr_q <= next_addr_calc;
                beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ei_axi4_wbeat_gen.sv
// Self-checking bench for ei_axi4_wbeat_gen (BUS_BYTE_LANES=4) with a byte-address reference model.
// Honours EI_AXI4_WBEAT_4KB_CHECK_EN when the design is built with it.
module tb_ei_axi4_wbeat_gen;

    localparam int LANES = 4;
    localparam int DW    = 8 * LANES;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_addr = '0;
    logic [1:0]       cmd_burst = '0;
    logic [2:0]       cmd_size = '0;
    logic [7:0]       cmd_len = '0;
    logic             src_valid = 1'b0;
    logic             src_ready;
    logic [DW-1:0]    src_data = '0;
    logic             wvalid;
    logic             wready = 1'b0;
    logic [DW-1:0]    wdata;
    logic [LANES-1:0] wstrb;
    logic             wlast;
    logic             busy;
    logic             cmd_err;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    ei_axi4_wbeat_gen #(.BUS_BYTE_LANES(LANES)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_size  (cmd_size),
        .cmd_len   (cmd_len),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    // Legality from the command rules, using plain integer arithmetic.
    function automatic bit model_legal(input logic [31:0] a, input logic [1:0] b,
                                       input logic [2:0] s, input logic [7:0] l);
        longint bytes = longint'(1) << s;
        longint astart = longint'(a) - (longint'(a) % bytes);
        if (bytes > LANES) return 1'b0;
        if (b == 2'd3) return 1'b0;
        if (b == 2'd2) begin
            if (!(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) return 1'b0;
            if ((longint'(a) % bytes) != 0) return 1'b0;
        end
`ifdef EI_AXI4_WBEAT_4KB_CHECK_EN
        if (b == 2'd1 && ((astart % 4096) + bytes * (longint'(l) + 1) > 4096)) return 1'b0;
`else
        if (astart < 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Expected strobe: address of beat n, then mark the lane of every byte it transfers.
    function automatic logic [LANES-1:0] model_strb(input logic [31:0] a, input logic [1:0] b,
                                                    input logic [2:0] s, input logic [7:0] l,
                                                    input int n);
        longint bytes = longint'(1) << s;
        longint total = bytes * (longint'(l) + 1);
        longint astart = longint'(a) - (longint'(a) % bytes);
        longint lower;
        longint ba;
        logic [LANES-1:0] strb = '0;
        if (b == 2'd0)      ba = longint'(a);
        else if (b == 2'd1) ba = (n == 0) ? longint'(a) : ((astart + n * bytes) & 64'hFFFF_FFFF);
        else begin
            lower = astart - (astart % total);
            ba = lower + ((astart - lower + n * bytes) % total);
        end
        for (longint k = 0; k < bytes - (ba % bytes); k++)
            strb[int'((ba + k) % LANES)] = 1'b1;
        return strb;
    endfunction

    // mode 0: random valid/ready, 1: wready 1,0,0,1 with src gaps, 2: always ready.
    // abort_after >= 0 asserts areset once that many beats have completed.
    task automatic run_burst(input logic [31:0] a, input logic [1:0] b, input logic [2:0] s,
                             input logic [7:0] l, input int mode, input int abort_after);
        bit               legal;
        bit               stalled = 1'b0;
        int               n = 0;
        int               cyc = 0;
        int               pat = 0;
        logic [LANES-1:0] exp_strb;
        logic [LANES-1:0] prev_strb = '0;
        logic             prev_last = 1'b0;
        logic [DW-1:0]    prev_data = '0;
        legal = model_legal(a, b, s, l);

        @(negedge aclk);
        cmd_addr = a; cmd_burst = b; cmd_size = s; cmd_len = l;
        cmd_valid = 1'b1; src_valid = 1'b0; wready = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle got %b want 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 1'b0; src_valid = 1'b1; wready = 1'b1;
        #1;
        if (!legal) begin
            checks++;
            if (cmd_err !== 1'b1 || busy !== 1'b0 || wvalid !== 1'b0) begin
                errors++;
                $display("FAIL cmd_err_pulse addr=%h got err=%b busy=%b wvalid=%b want 1 0 0",
                         a, cmd_err, busy, wvalid);
            end
            @(negedge aclk); #1;
            checks++;
            if (cmd_err !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL cmd_err_width got err=%b busy=%b want 0 0", cmd_err, busy);
            end
            src_valid = 1'b0; wready = 1'b0;
            return;
        end
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL burst_start got busy=%b cmd_ready=%b want 1 0", busy, cmd_ready);
        end

        while (n <= int'(l) && cyc < 400) begin
            if (abort_after == n) begin
                src_valid = 1'b1; wready = 1'b1; areset = 1'b1;
                #1;
                checks++;
                if (wvalid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
                    src_ready !== 1'b0 || wstrb !== '0 || wlast !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_burst got wvalid=%b busy=%b cmd_ready=%b src_ready=%b wstrb=%h wlast=%b want 0 0 1 0 0 0",
                             wvalid, busy, cmd_ready, src_ready, wstrb, wlast);
                end
                @(negedge aclk);
                areset = 1'b0; src_valid = 1'b0; wready = 1'b0;
                return;
            end
            if (stalled) src_valid = 1'b1;
            else begin
                src_valid = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
                src_data  = DW'($urandom);
            end
            if (mode == 2)      wready = 1'b1;
            else if (mode == 1) wready = ((pat % 4) == 0) || ((pat % 4) == 3);
            else                wready = ($urandom_range(0, 3) != 0);
            pat++;
            #1;
            exp_strb = model_strb(a, b, s, l, n);
            checks++;
            if (wvalid !== src_valid || src_ready !== wready || wdata !== src_data) begin
                errors++;
                $display("FAIL passthru beat %0d got wvalid=%b src_ready=%b wdata=%h want %b %b %h",
                         n, wvalid, src_ready, wdata, src_valid, wready, src_data);
            end
            checks++;
            if (wstrb !== exp_strb) begin
                errors++; $display("FAIL wstrb beat %0d got %h want %h", n, wstrb, exp_strb);
            end
            checks++;
            if (wlast !== (n == int'(l))) begin
                errors++; $display("FAIL wlast beat %0d got %b want %b", n, wlast, (n == int'(l)));
            end
            if (stalled) begin
                checks++;
                if (wstrb !== prev_strb || wlast !== prev_last || wdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold beat %0d got %h/%b/%h want %h/%b/%h",
                             n, wstrb, wlast, wdata, prev_strb, prev_last, prev_data);
                end
            end
            prev_strb = wstrb; prev_last = wlast; prev_data = wdata;
            stalled = src_valid && !wready;
            if (src_valid && wready) n++;
            cyc++;
            @(negedge aclk);
        end

        if (n <= int'(l)) begin
            errors++; $display("FAIL burst_timeout got %0d beats want %0d", n, int'(l) + 1);
        end else begin
            src_valid = 1'b1; wready = 1'b1;
            #1;
            checks++;
            if (busy !== 1'b0 || wvalid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL burst_end got busy=%b wvalid=%b cmd_ready=%b want 0 0 1",
                         busy, wvalid, cmd_ready);
            end
        end
        src_valid = 1'b0; wready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        src_valid = 1'b1; wready = 1'b1; cmd_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || src_ready !== 1'b0 || wvalid !== 1'b0 || wstrb !== '0 ||
            wlast !== 1'b0 || cmd_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got cmd_ready=%b src_ready=%b wvalid=%b wstrb=%h wlast=%b cmd_err=%b busy=%b",
                     cmd_ready, src_ready, wvalid, wstrb, wlast, cmd_err, busy);
        end
        @(negedge aclk);
        areset = 1'b0; src_valid = 1'b0; wready = 1'b0;
    endtask

    task automatic test_incr_unaligned();
        run_burst(32'h0000_1001, 2'd1, 3'd2, 8'd3, 2, -1);
    endtask

    task automatic test_wrap();
        run_burst(32'h0000_0006, 2'd2, 3'd1, 8'd3, 2, -1);
        run_burst(32'h0000_0038, 2'd2, 3'd2, 8'd7, 0, -1);
    endtask

    task automatic test_fixed();
        run_burst(32'h0000_0003, 2'd0, 3'd1, 8'd1, 2, -1);
    endtask

    task automatic test_stall();
        run_burst(32'h0000_2000, 2'd1, 3'd2, 8'd7, 1, -1);
        run_burst(32'h0000_2005, 2'd0, 3'd0, 8'd5, 1, -1);
    endtask

    task automatic test_illegal();
        run_burst(32'h0000_0000, 2'd1, 3'd3, 8'd0, 2, -1);
        run_burst(32'h0000_0000, 2'd2, 3'd1, 8'd2, 2, -1);
        run_burst(32'h0000_0000, 2'd3, 3'd0, 8'd0, 2, -1);
        run_burst(32'h0000_0002, 2'd2, 3'd2, 8'd3, 2, -1);
    endtask

    task automatic test_4kb();
        run_burst(32'h0000_0FF8, 2'd1, 3'd2, 8'd3, 2, -1);
    endtask

    task automatic test_reset_mid_burst();
        run_burst(32'h0000_0100, 2'd1, 3'd2, 8'd3, 2, 2);
        run_burst(32'h0000_0102, 2'd1, 3'd1, 8'd3, 2, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  b;
        logic [2:0]  s;
        logic [7:0]  l;
        for (int i = 0; i < 30; i++) begin
            s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            b = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFF0 | 12'($urandom_range(0, 15));
            l = 8'($urandom_range(0, 15));
            if (b == 2'd2 && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0: l = 8'd1;
                    1: l = 8'd3;
                    2: l = 8'd7;
                    default: l = 8'd15;
                endcase
                a = a & ~((32'd1 << s) - 32'd1);
            end
            run_burst(a, b, s, l, int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_incr_unaligned();
        test_wrap();
        test_fixed();
        test_stall();
        test_illegal();
        test_4kb();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/ei_axi4_wbeat_gen.md
EI_AXI4_WBEAT_GEN -- requirements
Module: ei_axi4_wbeat_gen

Interface
- REQ-001 SHALL have parameter BUS_BYTE_LANES, default 4: write data bus width in bytes (power of 2, 1..128).
- REQ-002 SHALL have port aclk, input, 1: the single clock; all logic on rising edge.
- REQ-003 SHALL have port areset, input, 1: asynchronous, active-high reset.
- REQ-004 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_addr (in, 32), cmd_burst (in, 2; FIXED=0, INCR=1, WRAP=2), cmd_size (in, 3), cmd_len (in, 8): the write-burst command.
- REQ-005 SHALL have ports src_valid (in, 1), src_ready (out, 1), src_data (in, 8*BUS_BYTE_LANES): the upstream beat payload.
- REQ-006 SHALL have ports wvalid (out, 1), wready (in, 1), wdata (out, 8*BUS_BYTE_LANES), wstrb (out, BUS_BYTE_LANES), wlast (out, 1): the AXI4 W channel.
- REQ-007 SHALL have ports busy (out, 1), high outside IDLE, and cmd_err (out, 1), a one-cycle pulse when a command is rejected.

Function
- REQ-008 SHALL implement the FSM states IDLE and BURST.
- REQ-009 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready a legal command moves the FSM to BURST next cycle.
- REQ-010 SHALL reject an illegal command: accept it, pulse cmd_err the next cycle, and stay in IDLE. Illegal means any of: 2**cmd_size > BUS_BYTE_LANES; cmd_burst==3; WRAP with cmd_len not in {1,3,7,15}; WRAP with cmd_addr not size-aligned.
- REQ-011 SHALL, in BURST, set wvalid=src_valid, src_ready=wready and wdata=src_data, combinationally and with zero added latency.
- REQ-012 SHALL hold a registered beat counter (0..cmd_len) and a current address; both advance only on wvalid&wready.
- REQ-013 SHALL compute wstrb for beat 0 and for every FIXED beat as: size mask shifted left by (addr mod 2**size), truncated to 2**size bits, then shifted by (aligned addr mod BUS_BYTE_LANES).
- REQ-014 SHALL compute wstrb for INCR beat n>0 from the address start+n*2**size, size-aligned: the full size mask shifted by (addr mod BUS_BYTE_LANES).
- REQ-015 SHALL compute WRAP addresses within boundary lower=start-(start mod (2**size*(len+1))); an address reaching lower+2**size*(len+1) SHALL wrap to lower.
- REQ-016 SHALL keep wstrb, wlast and wdata stable while wvalid=1 and wready=0.
- REQ-017 SHALL assert wlast only when the beat counter equals cmd_len; on the handshake of that beat the FSM returns to IDLE, and cmd_ready rises the following cycle (no same-cycle command overlap).
- REQ-018 SHALL perform all address arithmetic modulo 2**32.

Reset
- REQ-019 SHALL, on areset high and regardless of the clock, enter IDLE immediately and force cmd_ready=1, src_ready=0, wvalid=0, wstrb=0, wlast=0, cmd_err=0, busy=0, beat counter=0 and address=0.
- REQ-020 SHALL abandon any burst in progress when reset arrives mid-burst, with no resume after reset release.

Configuration
- REQ-021 SHALL, with EI_AXI4_WBEAT_4KB_CHECK_EN defined, treat as illegal (per REQ-010) any INCR command whose last byte lies in a different 4KB page than cmd_addr; without the macro such commands SHALL be accepted and executed normally.

Structure
- REQ-022 SHALL place the burst-type enum (FIXED/INCR/WRAP), the FSM state typedef and the 4KB page constant in the shared package ei_axi4_pkg.
- REQ-023 SHALL implement strobe/address computation in the sub-module ei_axi4_wstrb_calc: purely combinational, taking (addr, burst, size, len, beat_no) and returning wstrb and next address.

Verification (BUS_BYTE_LANES=4)
- REQ-024 SHALL cover INCR, addr 0x1001, size 2, len 3 -> wstrb 0xE,0xF,0xF,0xF; wlast only on beat 4; busy falls after beat 4.
- REQ-025 SHALL cover WRAP, addr 0x6, size 1, len 3 -> addresses 6,0,2,4; wstrb 0xC,0x3,0xC,0x3.
- REQ-026 SHALL cover FIXED, addr 0x3, size 1, len 1 -> wstrb 0x8 on both beats; wlast on beat 2.
- REQ-027 SHALL cover INCR with wready toggling 1,0,0,1 and src_valid gaps -> outputs held stable during stalls; beat count exact.
- REQ-028 SHALL cover illegal commands, size 3 and WRAP len 2 -> cmd_err one-cycle pulse, no wvalid, FSM in IDLE. Also INCR addr 0xFF8, size 2, len 3 -> cmd_err with the macro, normal 4-beat burst without.
- REQ-029 SHALL cover areset asserted after beat 2 of a 4-beat burst -> wvalid=0 immediately; next command after release starts at beat 0.
